// File: rtl/factor_cycler_pkg.sv
// Shared types and elaboration-time helpers for the factor_cycler slice.
// Build option: FACTOR_CYCLER_PRIME_ONLY_EN restricts flagged divisors to primes.
package factor_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

  function automatic bit is_prime(input int n);
    bit p;
    p = (n >= 2);
    for (int k = 2; k < n; k++) begin
      if (n % k == 0) p = 1'b0;
    end
    return p;
  endfunction

  function automatic int div_w(input int max_div);
    return $clog2(max_div + 1);
  endfunction

endpackage

// File: rtl/factor_cycler_if.sv
// Operand and display bundle between the switch inputs and the digit/GPIO side.
// master drives the operand; slave (the cycler) drives the results.
interface factor_cycler_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_DIV = 15
);
  import factor_pkg::*;

  localparam int DIV_W = div_w(MAX_DIV);

  logic [WIDTH-1:0]   number;
  logic [DIV_W-1:0]   digit;
  logic               digit_valid;
  logic [MAX_DIV-2:0] factor_mask;
  logic               busy;
  logic               done;
  logic               is_zero;

  modport master (
    output number,
    input  digit, digit_valid, factor_mask, busy, done, is_zero
  );

  modport slave (
    input  number,
    output digit, digit_valid, factor_mask, busy, done, is_zero
  );

endinterface

// File: rtl/factor_cycler_mod_serial.sv
// Restoring shift-subtract modulo; remainder valid with a one-cycle done pulse
// exactly WIDTH cycles after start. A start while busy restarts the division.
module mod_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;

  function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] r,
                                                input logic             b,
                                                input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] t;
    t = {r, b};
    if (t >= {1'b0, dv}) t = t - {1'b0, dv};
    return t[WIDTH-1:0];
  endfunction

  // The start edge already performs the first bit, so done lands WIDTH cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= (WIDTH > 1);
        done <= (WIDTH == 1);
        cnt  <= CW'(WIDTH - 1);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_q   <= sub_step('0, dividend[WIDTH-1], divisor);
      shift_q <= dividend << 1;
      div_q   <= divisor;
    end else if (busy) begin
      rem_q   <= sub_step(rem_q, shift_q[WIDTH-1], div_q);
      shift_q <= shift_q << 1;
    end
  end

  assign remainder = rem_q;

endmodule

// File: rtl/factor_cycler.sv
// Trial-division factor finder that cycles the found divisors on a digit output.
// Build option: FACTOR_CYCLER_PRIME_ONLY_EN flags prime divisors only.
module factor_cycler
  import factor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_DIV = 15,
  parameter int DWELL   = 10_000_000
) (
  input  logic      clk,
  input  logic      reset,
  factor_cycler_if.slave bus
);

  localparam int DIV_W = div_w(MAX_DIV);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int MW    = MAX_DIV - 1;

`ifdef FACTOR_CYCLER_PRIME_ONLY_EN
  function automatic logic [MW-1:0] prime_mask();
    logic [MW-1:0] m;
    for (int i = 0; i < MW; i++) m[i] = is_prime(i + 2);
    return m;
  endfunction
  localparam logic [MW-1:0] KEEP_MASK = prime_mask();
`else
  localparam logic [MW-1:0] KEEP_MASK = '1;
`endif

  state_t           state;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] op_q;
  logic [DIV_W-1:0] d_q;
  logic [DIV_W-1:0] digit_q;
  logic [DIV_W-1:0] next_digit;
  logic [MW-1:0]    mask_q;
  logic [MW-1:0]    d_bit;
  logic [CNT_W-1:0] dwell_q;
  logic             start_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             mod_done;
  logic [WIDTH-1:0] mod_rem;
  logic             chg;

  assign chg = (bus.number != num_q);

  always_comb begin
    d_bit = '0;
    for (int i = 0; i < MW; i++) begin
      if (int'(d_q) == i + 2) d_bit[i] = 1'b1;
    end
  end

  // Lowest set divisor above the one on display, else wrap to 1.
  always_comb begin
    next_digit = DIV_W'(1);
    for (int i = MW - 1; i >= 0; i--) begin
      if (mask_q[i] && (i + 2 > int'(digit_q))) next_digit = DIV_W'(i + 2);
    end
  end

  mod_serial #(.WIDTH(WIDTH)) u_mod (
    .clk       (clk),
    .reset     (reset),
    .start     (start_q),
    .dividend  (op_q),
    .divisor   (WIDTH'(d_q)),
    .done      (mod_done),
    .remainder (mod_rem)
  );

  always_ff @(posedge clk) begin
    if (chg) op_q <= bus.number;
  end

  // A done seen during a start cycle belongs to an abandoned division.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      num_q   <= '0;
      d_q     <= DIV_W'(2);
      digit_q <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      num_q   <= bus.number;
      zero_q  <= (bus.number == '0);
      start_q <= 1'b0;
      if (chg) begin
        mask_q  <= '0;
        digit_q <= '0;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
        dwell_q <= '0;
        d_q     <= DIV_W'(2);
        if (bus.number != '0) begin
          state   <= SCAN;
          busy_q  <= 1'b1;
          start_q <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end else begin
        case (state)
          SCAN: begin
            if (mod_done && !start_q) begin
              if (mod_rem == '0) mask_q <= mask_q | (d_bit & KEEP_MASK);
              if (d_q == DIV_W'(MAX_DIV)) begin
                state   <= SHOW;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                valid_q <= 1'b1;
                digit_q <= DIV_W'(1);
                dwell_q <= '0;
              end else begin
                d_q     <= d_q + DIV_W'(1);
                start_q <= 1'b1;
              end
            end
          end
          SHOW: begin
            if (dwell_q == CNT_W'(DWELL - 1)) begin
              dwell_q <= '0;
              digit_q <= next_digit;
            end else begin
              dwell_q <= dwell_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.factor_mask = mask_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.is_zero     = zero_q;

endmodule

// File: tb/tb_factor_cycler.sv
// Directed bench for factor_cycler (WIDTH=8, MAX_DIV=15, DWELL=4).
// Expectations follow FACTOR_CYCLER_PRIME_ONLY_EN when it is defined.
module tb_factor_cycler;

  localparam int WIDTH   = 8;
  localparam int MAX_DIV = 15;
  localparam int DWELL   = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef FACTOR_CYCLER_PRIME_ONLY_EN
  int seq12[6] = '{1, 2, 3, 1, 1, 1};
  int len12    = 3;
  int mask12   = 32'h003;
`else
  int seq12[6] = '{1, 2, 3, 4, 6, 12};
  int len12    = 6;
  int mask12   = 32'h417;
`endif
  int seq13[6] = '{1, 13, 1, 1, 1, 1};
  int seq35[6] = '{1, 5, 7, 1, 1, 1};
  int seq1[6]  = '{1, 1, 1, 1, 1, 1};

  factor_cycler_if #(.WIDTH(WIDTH), .MAX_DIV(MAX_DIV)) bus ();

  factor_cycler #(.WIDTH(WIDTH), .MAX_DIV(MAX_DIV), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digit"}, 32'(bus.digit), 32'd0);
    check({tag, "_valid"}, 32'(bus.digit_valid), 32'd0);
    check({tag, "_mask"},  32'(bus.factor_mask), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_zero"},  32'(bus.is_zero), 32'd0);
  endtask

  // Called on the first sample after the change edge; counts busy samples.
  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    check({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check({tag, "_len"}, 32'(n), 32'd126);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_valid"}, 32'(bus.digit_valid), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int seq[6], input int len, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      check(tag, 32'(bus.digit), 32'(seq[(i / DWELL) % len]));
      tick();
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.number = '0;
    tick();
    tick();
    check_all_zero("reset");

    reset      = 1'b0;
    bus.number = 8'd12;
    tick();
    wait_scan("scan12");
    check("mask12", 32'(bus.factor_mask), 32'(mask12));
    check("busy12_end", 32'(bus.busy), 32'd0);
    check_seq("seq12", seq12, len12, (len12 + 1) * DWELL);

    bus.number = 8'd13;
    tick();
    wait_scan("scan13");
    check("mask13", 32'(bus.factor_mask), 32'h800);
    check_seq("seq13", seq13, 2, 12);

    bus.number = 8'd12;
    tick();
    check("mid_busy_a", 32'(bus.busy), 32'd1);
    repeat (49) tick();
    check("mid_partial_mask", 32'(bus.factor_mask[0]), 32'd1);
    bus.number = 8'd35;
    tick();
    check("mid_mask_clr", 32'(bus.factor_mask), 32'd0);
    wait_scan("scan35");
    check("mask35", 32'(bus.factor_mask), 32'h028);
    check_seq("seq35", seq35, 3, 16);

    bus.number = 8'd0;
    tick();
    check("zero_is_zero", 32'(bus.is_zero), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_valid", 32'(bus.digit_valid), 32'd0);
    check("zero_mask", 32'(bus.factor_mask), 32'd0);
    check("zero_done", 32'(bus.done), 32'd0);
    repeat (5) tick();
    check("zero_hold_busy", 32'(bus.busy), 32'd0);
    check("zero_hold_valid", 32'(bus.digit_valid), 32'd0);

    bus.number = 8'd1;
    tick();
    check("one_is_zero", 32'(bus.is_zero), 32'd0);
    wait_scan("scan1");
    check("mask1", 32'(bus.factor_mask), 32'd0);
    check_seq("seq1", seq1, 1, 12);

    bus.number = 8'd12;
    tick();
    wait_scan("scan12b");
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    tick();
    wait_scan("scan12c");
    check("mask12c", 32'(bus.factor_mask), 32'(mask12));
    check("digit12c", 32'(bus.digit), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
